// File: rtl/wb_arbiter.sv
// Writeback concentrator: per-channel result FIFOs drained round-robin onto
// NUM_WB_PORTS registered register-file write ports.
module wb_arbiter #(
   parameter int  NUM_EX_CH    = 4,
   parameter int  NUM_WB_PORTS = 2,
   parameter int  DATA_W       = 32,
   parameter int  NUM_PREGS    = 64,
   parameter int  FIFO_DEPTH   = 2,
   localparam int IDX_W        = $clog2(NUM_PREGS)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic [NUM_EX_CH-1:0]           ex_valid,
   output logic [NUM_EX_CH-1:0]           ex_ready,
   input  logic [NUM_EX_CH*DATA_W-1:0]    ex_dst_val,
   input  logic [NUM_EX_CH*IDX_W-1:0]     ex_dst_index,
   output logic [NUM_WB_PORTS-1:0]        wb_valid,
   output logic [NUM_WB_PORTS*DATA_W-1:0] wb_dst_val,
   output logic [NUM_WB_PORTS*IDX_W-1:0]  wb_dst_index,
   output logic                           idle
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int CH_W  = $clog2(NUM_EX_CH);

   logic [DATA_W-1:0] val_q    [NUM_EX_CH][FIFO_DEPTH];
   logic [IDX_W-1:0]  idx_q    [NUM_EX_CH][FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q [NUM_EX_CH];
   logic [PTR_W-1:0]  wr_ptr_q [NUM_EX_CH];
   logic [CNT_W-1:0]  cnt_q    [NUM_EX_CH];
   logic [CNT_W-1:0]  cnt_d    [NUM_EX_CH];
   logic [CH_W-1:0]   rr_ptr_q;
   logic [CH_W-1:0]   rr_ptr_d;

   logic [NUM_WB_PORTS-1:0]        wb_valid_q;
   logic [NUM_WB_PORTS*DATA_W-1:0] wb_val_q;
   logic [NUM_WB_PORTS*IDX_W-1:0]  wb_idx_q;

   logic [NUM_EX_CH-1:0]    push;
   logic [NUM_EX_CH-1:0]    grant;
   logic [NUM_EX_CH-1:0]    not_empty;
   logic [NUM_WB_PORTS-1:0] port_vld;
   logic [CH_W-1:0]         port_ch [NUM_WB_PORTS];

   // Ready depends on stored count only, so a full FIFO never takes a push
   // in the cycle it is popped.
   always_comb begin
      for (int c = 0; c < NUM_EX_CH; c++) begin
         not_empty[c] = (cnt_q[c] != '0);
         ex_ready[c]  = (cnt_q[c] < CNT_W'(FIFO_DEPTH));
         push[c]      = ex_valid[c] & ex_ready[c];
      end
   end

   always_comb begin
      logic [CH_W:0] ch_w;
      logic [CH_W:0] nxt_w;
      int            n;
      grant    = '0;
      port_vld = '0;
      for (int k = 0; k < NUM_WB_PORTS; k++) port_ch[k] = '0;
      rr_ptr_d = rr_ptr_q;
      ch_w     = '0;
      nxt_w    = '0;
      n        = 0;
      for (int i = 0; i < NUM_EX_CH; i++) begin
         ch_w = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
         if (ch_w >= (CH_W+1)'(NUM_EX_CH)) ch_w = ch_w - (CH_W+1)'(NUM_EX_CH);
         if (not_empty[ch_w[CH_W-1:0]] && (n < NUM_WB_PORTS)) begin
            grant[ch_w[CH_W-1:0]] = 1'b1;
            for (int k = 0; k < NUM_WB_PORTS; k++) begin
               if (k == n) begin
                  port_vld[k] = 1'b1;
                  port_ch[k]  = ch_w[CH_W-1:0];
               end
            end
            nxt_w = ch_w + (CH_W+1)'(1);
            if (nxt_w == (CH_W+1)'(NUM_EX_CH)) nxt_w = '0;
            rr_ptr_d = nxt_w[CH_W-1:0];
            n++;
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_EX_CH; c++)
         cnt_d[c] = cnt_q[c] + CNT_W'(push[c]) - CNT_W'(grant[c]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rr_ptr_q   <= '0;
         wb_valid_q <= '0;
         for (int c = 0; c < NUM_EX_CH; c++) begin
            rd_ptr_q[c] <= '0;
            wr_ptr_q[c] <= '0;
            cnt_q[c]    <= '0;
         end
         if (!rst_n) begin
            wb_val_q <= '0;
            wb_idx_q <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         for (int c = 0; c < NUM_EX_CH; c++) begin
            cnt_q[c] <= cnt_d[c];
            if (push[c]) begin
               val_q[c][wr_ptr_q[c]] <= ex_dst_val[c*DATA_W +: DATA_W];
               idx_q[c][wr_ptr_q[c]] <= ex_dst_index[c*IDX_W +: IDX_W];
               wr_ptr_q[c]           <= wr_ptr_q[c] + PTR_W'(1);
            end
            if (grant[c]) rd_ptr_q[c] <= rd_ptr_q[c] + PTR_W'(1);
         end
         wb_valid_q <= port_vld;
         for (int k = 0; k < NUM_WB_PORTS; k++) begin
            if (port_vld[k]) begin
               wb_val_q[k*DATA_W +: DATA_W] <= val_q[port_ch[k]][rd_ptr_q[port_ch[k]]];
               wb_idx_q[k*IDX_W +: IDX_W]   <= idx_q[port_ch[k]][rd_ptr_q[port_ch[k]]];
            end
         end
      end
   end

   assign wb_valid     = wb_valid_q;
   assign wb_dst_val   = wb_val_q;
   assign wb_dst_index = wb_idx_q;
   assign idle         = (not_empty == '0) && (wb_valid_q == '0);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (4 channels, 2 ports): latency, round-robin
// order, wrap, fairness under backpressure, flush and reset behaviour.
module tb_wb_arbiter;
   localparam int NCH = 4;
   localparam int NWB = 2;
   localparam int DW  = 32;
   localparam int IW  = 6;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic [NCH-1:0]    ex_valid = '0;
   logic [NCH-1:0]    ex_ready;
   logic [NCH*DW-1:0] ex_dst_val = '0;
   logic [NCH*IW-1:0] ex_dst_index = '0;
   logic [NWB-1:0]    wb_valid;
   logic [NWB*DW-1:0] wb_dst_val;
   logic [NWB*IW-1:0] wb_dst_index;
   logic              idle;

   int checks = 0;
   int failures = 0;

   wb_arbiter #(.NUM_EX_CH(NCH), .NUM_WB_PORTS(NWB), .DATA_W(DW), .NUM_PREGS(64), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_dst_val(ex_dst_val), .ex_dst_index(ex_dst_index),
      .wb_valid(wb_valid), .wb_dst_val(wb_dst_val), .wb_dst_index(wb_dst_index),
      .idle(idle)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int c, input logic [DW-1:0] v, input logic [IW-1:0] ix);
      ex_dst_val[c*DW +: DW]   = v;
      ex_dst_index[c*IW +: IW] = ix;
   endtask

   function automatic logic [DW-1:0] pval(input int k);
      return wb_dst_val[k*DW +: DW];
   endfunction

   function automatic logic [IW-1:0] pidx(input int k);
      return wb_dst_index[k*IW +: IW];
   endfunction

   // Rename guarantees distinct destinations on simultaneous writes.
   always @(negedge clk) begin
      if (rst_n && wb_valid == 2'b11)
         check_val("dup_idx", 64'(wb_dst_index[5:0] == wb_dst_index[11:6]), 64'd0);
   end

   initial begin
      int             seq [NCH];
      logic [NCH-1:0] acc;
      logic [DW-1:0]  v;
      int             j, b, got2, last2, maxgap, s2;
      logic           acc2;

      // reset state
      rst_n = 1'b0;
      step(); step();
      check_val("rst_wb_valid", 64'(wb_valid), 64'd0);
      check_val("rst_wb_val", 64'(wb_dst_val), 64'd0);
      check_val("rst_wb_idx", 64'(wb_dst_index), 64'd0);
      check_val("rst_ready", 64'(ex_ready), 64'hF);
      check_val("rst_idle", 64'(idle), 64'd1);
      rst_n = 1'b1;

      // single result: two-cycle latency then idle
      ex_valid = 4'b0010;
      drive(1, 32'hDEADBEEF, 6'd5);
      step();
      ex_valid = '0;
      check_val("single_busy", 64'(idle), 64'd0);
      check_val("single_not_yet", 64'(wb_valid), 64'd0);
      step();
      check_val("single_valid", 64'(wb_valid), 64'b01);
      check_val("single_val", 64'(pval(0)), 64'hDEADBEEF);
      check_val("single_idx", 64'(pidx(0)), 64'd5);
      step();
      check_val("single_done", 64'(wb_valid), 64'd0);
      check_val("single_idle", 64'(idle), 64'd1);

      // full contention from rr_ptr=0
      flush = 1'b1; step(); flush = 1'b0;
      for (int c = 0; c < NCH; c++) seq[c] = 0;
      ex_valid = '1;
      for (int e = 1; e <= 10; e++) begin
         for (int c = 0; c < NCH; c++) drive(c, DW'((c << 8) | seq[c]), IW'((c << 4) | (seq[c] & 15)));
         acc = ex_ready;
         step();
         for (int c = 0; c < NCH; c++) if (acc[c]) seq[c]++;
         if (e == 1) begin
            check_val("cont_first_valid", 64'(wb_valid), 64'd0);
            check_val("cont_first_ready", 64'(ex_ready), 64'hF);
         end else begin
            b = (e % 2 == 0) ? 0 : 2;
            j = (e % 2 == 0) ? (e - 2) / 2 : (e - 3) / 2;
            check_val("cont_valid", 64'(wb_valid), 64'b11);
            check_val("cont_p0", 64'(pval(0)), 64'((b << 8) | j));
            check_val("cont_p1", 64'(pval(1)), 64'(((b + 1) << 8) | j));
            check_val("cont_ready", 64'(ex_ready), (e % 2 == 0) ? 64'b0011 : 64'b1100);
         end
      end
      ex_valid = '0;

      // flush with 5 buffered entries and a simultaneous push
      flush = 1'b1; step(); flush = 1'b0;
      ex_valid = 4'hF;
      for (int c = 0; c < NCH; c++) drive(c, DW'(32'hF000 | c), IW'(32 + c));
      step();
      ex_valid = 4'b0111;
      for (int c = 0; c < NCH; c++) drive(c, DW'(32'hF010 | c), IW'(40 + c));
      step();
      check_val("fl_pre_valid", 64'(wb_valid), 64'b11);
      check_val("fl_pre_ready", 64'(ex_ready), 64'b1011);
      check_val("fl_pre_idle", 64'(idle), 64'd0);
      flush = 1'b1;
      ex_valid = 4'hF;
      for (int c = 0; c < NCH; c++) drive(c, DW'(32'hBAD0 | c), IW'(48 + c));
      step();
      flush = 1'b0;
      ex_valid = '0;
      check_val("fl_valid", 64'(wb_valid), 64'd0);
      check_val("fl_idle", 64'(idle), 64'd1);
      check_val("fl_ready", 64'(ex_ready), 64'hF);
      for (int i = 0; i < 4; i++) begin
         step();
         check_val("fl_no_stale", 64'(wb_valid), 64'd0);
      end

      // wrap: rr_ptr=3 with ch3 and ch0 pending
      ex_valid = 4'b0100;
      drive(2, 32'h2222, 6'd2);
      step();
      ex_valid = 4'b1001;
      drive(3, 32'h3333, 6'd3);
      drive(0, 32'h1010, 6'd10);
      step();
      ex_valid = '0;
      check_val("wrap_ch2_valid", 64'(wb_valid), 64'b01);
      check_val("wrap_ch2_val", 64'(pval(0)), 64'h2222);
      step();
      check_val("wrap_valid", 64'(wb_valid), 64'b11);
      check_val("wrap_p0", 64'(pval(0)), 64'h3333);
      check_val("wrap_p0_idx", 64'(pidx(0)), 64'd3);
      check_val("wrap_p1", 64'(pval(1)), 64'h1010);
      check_val("wrap_p1_idx", 64'(pidx(1)), 64'd10);
      ex_valid = 4'hF;
      for (int c = 0; c < NCH; c++) drive(c, DW'(32'h4400 | c), IW'(56 + c));
      step();
      ex_valid = '0;
      step();
      check_val("rr1_p0", 64'(pval(0)), 64'h4401);
      check_val("rr1_p1", 64'(pval(1)), 64'h4402);
      step();
      check_val("rr3_p0", 64'(pval(0)), 64'h4403);
      check_val("rr3_p1", 64'(pval(1)), 64'h4400);
      step();
      check_val("wrap_idle", 64'(idle), 64'd1);

      // backpressure: ch2 sends 6 results while the others saturate
      got2 = 0; last2 = -1; maxgap = 0; s2 = 0;
      drive(0, 32'hB00000FF, 6'd0);
      drive(1, 32'hB00001FF, 6'd8);
      drive(3, 32'hB00003FF, 6'd24);
      drive(2, DW'(32'hB0000200 | s2), IW'(16 + s2));
      ex_valid = 4'hF;
      for (int cyc = 0; cyc < 30; cyc++) begin
         acc2 = ex_valid[2] & ex_ready[2];
         step();
         if (acc2) begin
            s2++;
            if (s2 == 6) ex_valid[2] = 1'b0;
            else drive(2, DW'(32'hB0000200 | s2), IW'(16 + s2));
         end
         for (int k = 0; k < NWB; k++) begin
            v = pval(k);
            if (wb_valid[k] && v[31:8] == 24'hB00002) begin
               check_val("bp_order", 64'(v[7:0]), 64'(got2));
               got2++;
               if (last2 >= 0 && cyc - last2 > maxgap) maxgap = cyc - last2;
               last2 = cyc;
            end
         end
      end
      ex_valid = '0;
      check_val("bp_count", 64'(got2), 64'd6);
      check_val("bp_fair", 64'(maxgap <= 2), 64'd1);

      // reset mid-operation
      ex_valid = 4'hF;
      step(); step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      ex_valid = '0;
      check_val("mrst_valid", 64'(wb_valid), 64'd0);
      check_val("mrst_val", 64'(wb_dst_val), 64'd0);
      check_val("mrst_idx", 64'(wb_dst_index), 64'd0);
      check_val("mrst_ready", 64'(ex_ready), 64'hF);
      check_val("mrst_idle", 64'(idle), 64'd1);
      ex_valid = 4'b0001;
      drive(0, 32'h5A5A5A5A, 6'd7);
      step();
      ex_valid = '0;
      check_val("mrst_lat1", 64'(wb_valid), 64'd0);
      step();
      check_val("mrst_lat2", 64'(wb_valid), 64'b01);
      check_val("mrst_p0", 64'(pval(0)), 64'h5A5A5A5A);
      check_val("mrst_p0_idx", 64'(pidx(0)), 64'd7);
      step();
      check_val("mrst_idle_end", 64'(idle), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

- Parametrised writeback concentrator between the execute units and the physical register file.
- Accepts results from `NUM_EX_CH` execute channels using a valid/ready handshake.
- Buffers each channel in a small FIFO.
- Each cycle, grants up to `NUM_WB_PORTS` results round-robin onto registered register-file write ports.
- Replaces the single unbuffered execute→regfile write path. Execute units may now stall instead of colliding.

## Interface

Parameters:
- `NUM_EX_CH`, 4, number of execute result channels (≥2).
- `NUM_WB_PORTS`, 2, number of regfile write ports (1..`NUM_EX_CH`).
- `DATA_W`, 32, result width.
- `NUM_PREGS`, 64, physical register count; `IDX_W = $clog2(NUM_PREGS)`.
- `FIFO_DEPTH`, 2, entries per channel FIFO (power of two, ≥2).

Ports:
- `clk`  in  1  sole clock. All logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  synchronous squash of all buffered and output results.
- `ex_valid`  in  `NUM_EX_CH`  per-channel result valid.
- `ex_ready`  out  `NUM_EX_CH`  per-channel accept (FIFO not full).
- `ex_dst_val`  in  `NUM_EX_CH*DATA_W`  packed results; channel c occupies `[c*DATA_W +: DATA_W]`.
- `ex_dst_index`  in  `NUM_EX_CH*IDX_W`  packed destination preg indices.
- `wb_valid`  out  `NUM_WB_PORTS`  registered write enable per port.
- `wb_dst_val`  out  `NUM_WB_PORTS*DATA_W`  registered write data.
- `wb_dst_index`  out  `NUM_WB_PORTS*IDX_W`  registered write index.
- `idle`  out  1  all FIFOs empty and `wb_valid == 0`.

## Operation

- **Push.** Channel c pushes `{ex_dst_val[c], ex_dst_index[c]}` when `ex_valid[c] && ex_ready[c]`.
  - `ex_ready[c] = (count[c] < FIFO_DEPTH)` is combinational from state only.
  - A full FIFO does not accept a push in the same cycle as its pop. No full-pass-through.
- **FIFO.** Each channel FIFO has read pointer, write pointer and count. Pointers wrap modulo `FIFO_DEPTH`. Order within a channel is preserved.
- **Arbitration.** The arbiter is combinational over the FIFO heads.
  - Scan channels starting at `rr_ptr`, wrapping modulo `NUM_EX_CH`.
  - The first `NUM_WB_PORTS` non-empty channels are granted.
  - The k-th grant in scan order drives port k. Granted heads are popped.
  - Ungranted ports load `wb_valid[k]=0`. Their data/index hold the previous value (don't-care).
- **Pointer update.**
  - If any grant occurred: `rr_ptr ← (last granted channel + 1) mod NUM_EX_CH`.
  - Otherwise `rr_ptr` is unchanged.
- **Fairness.** A non-empty channel is granted within `ceil(NUM_EX_CH/NUM_WB_PORTS)` arbitration cycles.
- **Flush.** In the cycle `flush=1`:
  - all counts and pointers clear;
  - `wb_valid ← 0`;
  - pushes are ignored (flush beats push);
  - `rr_ptr ← 0`.
  - `ex_ready` in the flush cycle still reflects the pre-flush counts.
- **Reset.** Reset (`rst_n=0`) has the same effect as flush. Reset has priority over everything.
  - Outputs after reset: `wb_valid=0`, `wb_dst_val=0`, `wb_dst_index=0`, `ex_ready` all 1, `idle=1`.
  - Reset asserted mid-stream discards all in-flight results.
- **Duplicate indices.** Two ports with the same `wb_dst_index` in one cycle is illegal; rename guarantees it never happens. The bench asserts this; the RTL does no checking.

## Timing

- **Latency.**
  - Push accepted at edge N → head eligible for arbitration in cycle N+1 → `wb_valid` high in cycle N+2.
  - Minimum latency is 2 cycles.
- **Throughput.** `NUM_WB_PORTS` results per cycle sustained. Per-channel throughput is 1 per cycle when uncontended and `FIFO_DEPTH≥2`.
- **Output duration.** `wb_valid` pulses for exactly one cycle per result. The regfile has no backpressure.
- **Registered outputs.** `wb_*` are flops. `idle` is combinational from FIFO counts and `wb_valid` flops.
- **Empty FIFO.** An empty FIFO is never granted. A push into an empty FIFO cannot be granted in the same cycle (no bypass).

## Test plan

- **Single result.** After reset, ch1 pushes val=0xDEADBEEF, idx=5 at cycle 0.
  - Required: `wb_valid=2'b01`, port 0 = {0xDEADBEEF, 5} at cycle 2.
  - Required: `idle=1` again at cycle 3.
- **Full contention, 4ch/2 ports.** All channels push every cycle, with val=(ch<<8)|seq.
  - Required grant pairs: {0,1},{2,3},{0,1},…
  - Required: each channel's results appear in seq order.
  - Required: `ex_ready` deasserts per channel once its count reaches 2.
  - Required: 2 writes per cycle, sustained.
- **Wrap.** Only ch3 and ch0 non-empty, `rr_ptr=3`.
  - Required: port0=ch3, port1=ch0, `rr_ptr→1`.
- **Backpressure.** Hold `ex_valid[2]=1` for 6 cycles while ch0, ch1 and ch3 saturate.
  - Required: ch2 never waits >2 arbitration cycles.
  - Required: no result is lost or duplicated (scoreboard count = 6).
- **Flush mid-stream.** Flush with 5 buffered entries and a push in the same cycle.
  - Required: `wb_valid=0` next cycle.
  - Required: the flushed-cycle push is absent.
  - Required: `idle=1` next cycle, and no stale write ever appears.
- **Reset mid-operation.** Drop `rst_n` for 1 cycle during saturation.
  - Required: all outputs are at reset values the cycle after.
  - Required: a subsequent push completes with 2-cycle latency.
